load_store_unit: RTL and testbench
==================================

# load_store_unit

- Sits directly upstream of the word-addressed `data_memory` and drives its `MemRead`/`MemWrite`/`addr_i`/`write_data_i` ports.
- Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses, using read-modify-write for sub-word stores.
- Extracts and extends load data, and flags misaligned, illegal or out-of-range accesses.
- One request in flight; response is a single-cycle pulse back to the pipeline's MEM stage.

## Interface
Parameters:
- `DEPTH`, 256, number of 32-bit words in the downstream memory; used for bounds checking.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: unit idle, request accepted when both high.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32I funct3 width/sign code.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `resp_valid_o` out 1: one-cycle completion pulse.
- `resp_err_o` out 1: completion was a fault; qualified by `resp_valid_o`.
- `resp_rdata_o` out 32: extended load data.
- `mem_read_o` out 1: to `MemRead`.
- `mem_write_o` out 1: to `MemWrite`.
- `mem_addr_o` out 32: word-aligned address (`[1:0]`=0).
- `mem_wdata_o` out 32: full word to write.
- `mem_rdata_i` in 32: combinational read data from memory.

## Operation
FSM states: IDLE, LOAD, RMW_RD, RMW_WR, RESP.

- **IDLE**
  - `req_ready_o`=1; no other state asserts it.
  - On accept, latch we, funct3, addr and wdata.
  - Fault on accept goes to RESP with err=1. No memory strobe is raised.
  - Otherwise a load goes to LOAD, SW goes to RMW_WR with merged word = wdata, and SB/SH go to RMW_RD.
- **Faults**
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 > 010.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
- **LOAD**
  - `mem_read_o`=1.
  - Capture `mem_rdata_i` at cycle end.
  - Select byte lane `addr[1:0]` or half lane `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into `resp_rdata_o`, then go to RESP.
- **RMW_RD**
  - `mem_read_o`=1.
  - Register the merged word: memory word with the addressed byte/half replaced by `wdata[7:0]`/`wdata[15:0]`. Then go to RMW_WR.
- **RMW_WR**
  - `mem_write_o`=1, `mem_wdata_o`= merged word. Memory commits at this cycle's edge.
  - Then go to RESP.
- **RESP**
  - `resp_valid_o`=1 for exactly one cycle; no backpressure.
  - Always returns to IDLE.
- **Outputs outside their states**
  - `mem_read_o`/`mem_write_o` are never both 1.
  - `mem_addr_o`= latched addr with `[1:0]` cleared in LOAD/RMW_*; 0 in other states.
  - `mem_wdata_o`=0 outside RMW_WR.
- **Result register**
  - `resp_rdata_o` updates only on loads. It is 0 for stores and faults, and holds until the next response.

## Timing
Let cycle 0 be the cycle with valid&ready high in IDLE.

- **Latency**
  - Fault: RESP in cycle 1.
  - Load and SW: RESP in cycle 2.
  - SB/SH: RESP in cycle 3.
- **Throughput**: next accept no earlier than the cycle after RESP, so back-to-back LW runs at 3 cycles/op.
- **Reset**
  - Asserting `rst` at any time forces IDLE immediately.
  - All outputs go to 0 except `req_ready_o`, which goes to 1 while in IDLE after reset.
  - Reset during RMW_WR drops `mem_write_o` asynchronously. The store is aborted with no response.
- **Input stability**
  - Request inputs are ignored while `req_ready_o`=0.
  - Latched values are stable across the whole transaction.

## Configuration
- `LSU_BOUNDS_CHECK_EN` defined:
  - Any access with `addr[31:2]` ≥ DEPTH is a fault, with a response in cycle 1 and no memory strobe.
  - The check has priority equal to misalignment; both produce `resp_err_o`=1.
- Undefined:
  - No range check.
  - `mem_addr_o` carries the full aligned address; out-of-range behaviour is that of the memory.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams: LB/LH/LW/LBU/LHU, SB/SH/SW.
  - FSM state enum.
  - Byte/half lane-select helper functions.
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension.
  - Inputs: word, addr[1:0], funct3.
  - Instantiated once for the LOAD path.
- The store merge stays inline in the top.

## Test plan
- **Word round trip**: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → LW `resp_rdata_o`=0xDEADBEEF. LW response in cycle 2 after accept. Single `mem_write_o` pulse during the SW.
- **Sub-word store and signed loads**: word 0x11223344 at 0x20. SB addr 0x22 data 0xFF → word 0x11FF3344, response in cycle 3. Then LB 0x22 → 0xFFFFFFFF, LBU 0x22 → 0x000000FF.
- **Halfword loads**: word 0x8001_7FFE at 0x30. LH 0x32 → 0xFFFF8001, LHU 0x32 → 0x00008001, LH 0x30 → 0x00007FFE.
- **Faults**: LW 0x21, SH 0x23, load funct3=011 → `resp_err_o`=1 in cycle 1. `mem_read_o`/`mem_write_o` never assert; memory unchanged.
- **Bounds (macro on, DEPTH=256)**: LW 0x400 → err; LW 0x3FC → normal read.
- **Reset mid-RMW**: assert `rst` during RMW_WR of SB 0x21 → `mem_write_o` drops at once, no `resp_valid_o`. Target word is not committed; `req_ready_o`=1 after reset.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and lane-select helpers used by the load aligner and the fault check.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] off);
    return w[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] half_lane(input logic [31:0] w, input logic sel);
    return w[{sel, 4'b0000} +: 16];
  endfunction

  // Width/sign codes that do not exist, plus natural-alignment violations.
  function automatic logic req_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    if (we) bad = (f3 > F3_SW);
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if ((f3[1:0] == 2'b01) && a[0])          bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (a != 2'b00))  bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side bus of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; resp_valid_o is a one-cycle pulse with no backpressure.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
           mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
           mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the byte/half lane of a memory word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = byte_lane(word_i, off_i);
    h = half_lane(word_i, off_i[1]);
    case (funct3_i)
      F3_LB:   data_o = {{24{b[7]}}, b};
      F3_LBU:  data_o = {24'b0, b};
      F3_LH:   data_o = {{16{h[15]}}, h};
      F3_LHU:  data_o = {16'b0, h};
      default: data_o = word_i;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed memory; sub-word stores use
// read-modify-write. Optional range check enabled by `define LSU_BOUNDS_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus,
  output state_e             dbg_state_o
);
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_e      state_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;   // only the sub-word part is needed after accept
  logic        ready_q, resp_valid_q, err_q, rd_q, wr_q;
  logic [31:0] rdata_q, maddr_q, mwdata_q;

  logic        oob, fault;
  logic [31:0] load_data, merged;

  assign oob   = BOUNDS_EN && (bus.req_addr_i[31:2] >= DEPTH_W);
  assign fault = req_fault(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i[1:0]) || oob;

  lsu_load_align u_align (
    .word_i   (bus.mem_rdata_i),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    merged = bus.mem_rdata_i;
    if (f3_q == F3_SB) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else               merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      f3_q         <= 3'b0;
      addr_q       <= 32'b0;
      wdata_q      <= 16'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      maddr_q      <= 32'b0;
      mwdata_q     <= 32'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.req_valid_i) begin
          f3_q    <= bus.req_funct3_i;
          addr_q  <= bus.req_addr_i;
          wdata_q <= bus.req_wdata_i[15:0];
          ready_q <= 1'b0;
          if (fault) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b1;
            rdata_q      <= 32'b0;
          end else if (!bus.req_we_i) begin
            state_q <= ST_LOAD;
            rd_q    <= 1'b1;
            maddr_q <= {bus.req_addr_i[31:2], 2'b00};
          end else if (bus.req_funct3_i == F3_SW) begin
            // A full word needs no read: write it straight away.
            state_q  <= ST_RMW_WR;
            wr_q     <= 1'b1;
            maddr_q  <= {bus.req_addr_i[31:2], 2'b00};
            mwdata_q <= bus.req_wdata_i;
          end else begin
            state_q <= ST_RMW_RD;
            rd_q    <= 1'b1;
            maddr_q <= {bus.req_addr_i[31:2], 2'b00};
          end
        end
        ST_LOAD: begin
          state_q      <= ST_RESP;
          rd_q         <= 1'b0;
          maddr_q      <= 32'b0;
          rdata_q      <= load_data;
          resp_valid_q <= 1'b1;
          err_q        <= 1'b0;
        end
        ST_RMW_RD: begin
          state_q  <= ST_RMW_WR;
          rd_q     <= 1'b0;
          wr_q     <= 1'b1;
          mwdata_q <= merged;
        end
        ST_RMW_WR: begin
          state_q      <= ST_RESP;
          wr_q         <= 1'b0;
          maddr_q      <= 32'b0;
          mwdata_q     <= 32'b0;
          rdata_q      <= 32'b0;
          resp_valid_q <= 1'b1;
          err_q        <= 1'b0;
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          err_q        <= 1'b0;
          ready_q      <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          err_q        <= 1'b0;
          rd_q         <= 1'b0;
          wr_q         <= 1'b0;
          maddr_q      <= 32'b0;
          mwdata_q     <= 32'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = err_q;
  assign bus.resp_rdata_o = rdata_q;
  assign bus.mem_read_o   = rd_q;
  assign bus.mem_write_o  = wr_q;
  assign bus.mem_addr_o   = maddr_q;
  assign bus.mem_wdata_o  = mwdata_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-array memory, arithmetic reference
// model with an expected-response queue, per-cycle compare and literal checks.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int DEPTH = 256;

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  state_e dbg_state;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- downstream memory ----------------
  logic [31:0] dmem [DEPTH];
  assign bus.mem_rdata_i = dmem[bus.mem_addr_o[9:2]];
  always @(posedge clk) if (bus.mem_write_o) dmem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] ref_mem [DEPTH];
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_wr = 0;
  logic [31:0] cur_waddr = 32'h0;
  bit          cur_fault = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  int          last_resp_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: request semantics computed directly from the ISA rules.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output bit err,
                                output logic [31:0] rd, output int lat);
    int          idx;
    int          sh;
    int          hs;
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    bit          bad;
    idx = int'(addr[9:2]);
    sh  = int'(addr[1:0]) * 8;
    hs  = addr[1] ? 16 : 0;
    bad = 1'b0;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1'b1;
    if (we && f3 > 3'd2) bad = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) bad = 1'b1;
    if (f3 == 3'd2 && addr[1:0] != 2'd0) bad = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
    if ((addr >> 2) >= 32'(DEPTH)) bad = 1'b1;
`endif
    err = bad;
    rd  = 32'h0;
    lat = 1;
    if (bad) return;
    w = ref_mem[idx];
    if (!we) begin
      lat = 2;
      b = (w >> sh) & 32'hFF;
      h = (w >> hs) & 32'hFFFF;
      case (f3)
        3'd0:    rd = (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
        3'd1:    rd = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
        3'd4:    rd = b;
        3'd5:    rd = h;
        default: rd = w;
      endcase
    end else begin
      case (f3)
        3'd0: begin
          lat = 3;
          ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end
        3'd1: begin
          lat = 3;
          ref_mem[idx] = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
        end
        default: begin
          lat = 2;
          ref_mem[idx] = wd;
        end
      endcase
    end
  endfunction

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_read_o && bus.mem_write_o) begin
          n_vec++; n_err++;
          $display("FAIL strobe_excl: rd=%b wr=%b at cycle %0d", bus.mem_read_o, bus.mem_write_o, cyc);
        end
        if (bus.mem_read_o || bus.mem_write_o) begin
          n_vec++;
          if (cur_fault || bus.mem_addr_o !== cur_waddr) begin
            n_err++;
            $display("FAIL strobe_addr: got %h fault=%0b expected %h", bus.mem_addr_o, cur_fault, cur_waddr);
          end
        end
        if (bus.mem_write_o) n_wr++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          n_vec++;
          if (bus.resp_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL resp_missing: got valid=%b expected 1 at cycle %0d", bus.resp_valid_o, cyc);
          end else if (bus.resp_err_o !== e.err || bus.resp_rdata_o !== e.rdata) begin
            n_err++;
            $display("FAIL resp_data: got err=%b rdata=%h expected err=%b rdata=%h",
                     bus.resp_err_o, bus.resp_rdata_o, e.err, e.rdata);
          end
          last_rdata    = bus.resp_rdata_o;
          last_err      = bus.resp_err_o;
          last_resp_cyc = cyc;
        end else if (bus.resp_valid_o !== 1'b0) begin
          n_vec++; n_err++;
          $display("FAIL resp_unexpected: got valid=%b expected 0 at cycle %0d", bus.resp_valid_o, cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int b = 0;
    @(negedge clk);
    while (bus.req_ready_o !== 1'b1 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (bus.req_ready_o !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: got %b expected 1", bus.req_ready_o);
    end
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int acc);
    exp_t e;
    bit   err;
    logic [31:0] rd;
    int   lat;
    wait_ready();
    model(we, f3, addr, wd, err, rd, lat);
    cur_waddr        = {addr[31:2], 2'b00};
    cur_fault        = err;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    acc   = cyc;
    e.due = cyc + lat;
    e.err = err;
    e.rdata = rd;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (exp_q.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // One transaction to completion, then literal checks on its response.
  task automatic txn(input string name, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    int acc;
    issue(we, f3, addr, wd, acc);
    wait_idle();
    check({name, "_rdata"}, last_rdata, exp_rd);
    check({name, "_err"}, {31'b0, last_err}, {31'b0, exp_err});
    check({name, "_lat"}, 32'(last_resp_cyc - acc), 32'(exp_lat));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a0;
    int a1;
    int wr0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b0;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, bus.req_ready_o}, 32'h1);
    check("rst_resp_valid", {31'b0, bus.resp_valid_o}, 32'h0);
    check("rst_mem_rw", {30'b0, bus.mem_read_o, bus.mem_write_o}, 32'h0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    check("rst_rdata", bus.resp_rdata_o, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // word round trip
    wr0 = n_wr;
    txn("sw10", 1'b1, F3_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("sw10_wr_pulses", 32'(n_wr - wr0), 32'd1);
    txn("lw10", 1'b0, F3_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // sub-word store and signed byte loads
    txn("sw20", 1'b1, F3_SW, 32'h20, 32'h11223344, 32'h0, 1'b0, 2);
    txn("sb22", 1'b1, F3_SB, 32'h22, 32'h000000FF, 32'h0, 1'b0, 3);
    txn("lw20", 1'b0, F3_LW, 32'h20, 32'h0, 32'h11FF3344, 1'b0, 2);
    txn("lb22", 1'b0, F3_LB, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    txn("lbu22", 1'b0, F3_LBU, 32'h22, 32'h0, 32'h000000FF, 1'b0, 2);

    // halfword loads and a halfword store
    txn("sw30", 1'b1, F3_SW, 32'h30, 32'h80017FFE, 32'h0, 1'b0, 2);
    txn("lh32", 1'b0, F3_LH, 32'h32, 32'h0, 32'hFFFF8001, 1'b0, 2);
    txn("lhu32", 1'b0, F3_LHU, 32'h32, 32'h0, 32'h00008001, 1'b0, 2);
    txn("lh30", 1'b0, F3_LH, 32'h30, 32'h0, 32'h00007FFE, 1'b0, 2);
    txn("sh32", 1'b1, F3_SH, 32'h32, 32'h1234ABCD, 32'h0, 1'b0, 3);
    txn("lw30", 1'b0, F3_LW, 32'h30, 32'h0, 32'hABCD7FFE, 1'b0, 2);
    txn("lb33", 1'b0, F3_LB, 32'h33, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
    txn("lbu31", 1'b0, F3_LBU, 32'h31, 32'h0, 32'h0000007F, 1'b0, 2);

    // faults: no strobes, memory untouched
    wr0 = n_wr;
    txn("f_lw21", 1'b0, F3_LW, 32'h21, 32'h0, 32'h0, 1'b1, 1);
    txn("f_sh23", 1'b1, F3_SH, 32'h23, 32'h5555, 32'h0, 1'b1, 1);
    txn("f_ld011", 1'b0, 3'b011, 32'h30, 32'h0, 32'h0, 1'b1, 1);
    txn("f_st011", 1'b1, 3'b011, 32'h20, 32'h77, 32'h0, 1'b1, 1);
    check("fault_no_writes", 32'(n_wr - wr0), 32'd0);
    txn("lw20_keep", 1'b0, F3_LW, 32'h20, 32'h0, 32'h11FF3344, 1'b0, 2);

    // back-to-back loads
    issue(1'b0, F3_LW, 32'h10, 32'h0, a0);
    issue(1'b0, F3_LW, 32'h10, 32'h0, a1);
    wait_idle();
    check("b2b_spacing", 32'(a1 - a0), 32'd3);

    // top of the memory, and beyond it when range checking is built in
    txn("sw3fc", 1'b1, F3_SW, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    txn("lw3fc", 1'b0, F3_LW, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 2);
`ifdef LSU_BOUNDS_CHECK_EN
    txn("f_lw400", 1'b0, F3_LW, 32'h400, 32'h0, 32'h0, 1'b1, 1);
`endif

    // reset while the sub-word store is writing back
    wait_ready();
    cur_waddr        = 32'h20;
    cur_fault        = 1'b0;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = F3_SB;
    bus.req_addr_i   = 32'h21;
    bus.req_wdata_i  = 32'h000000AA;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("rmw_wr_strobe", {31'b0, bus.mem_write_o}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_drops_write", {31'b0, bus.mem_write_o}, 32'h0);
    check("rst_no_resp", {31'b0, bus.resp_valid_o}, 32'h0);
    check("rst_ready_async", {31'b0, bus.req_ready_o}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_after", {31'b0, bus.req_ready_o}, 32'h1);
    check("rst_word_kept", dmem[8], 32'h11FF3344);
    txn("lw20_after_rst", 1'b0, F3_LW, 32'h20, 32'h0, 32'h11FF3344, 1'b0, 2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
